// File: rtl/mic_adc_sampler_pkg.sv
// Shared types and constants for the mic ADC sampler.
// Frame latency helper is used for the elaboration-time period check.
package mic_adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_e;

    localparam int NULL_BITS_D = 2;
    localparam int ADC_BITS_D  = 12;
    localparam int FRAME_BITS  = NULL_BITS_D + ADC_BITS_D;

    function automatic int frame_latency(input int clk_div,
                                         input int frame_bits);
        return clk_div + 2 * clk_div * frame_bits + 1;
    endfunction

endpackage

// File: rtl/mic_adc_sampler_if.sv
// Serial ADC pins (SPI mode 0, read-only) between the
// sampler and the converter.
interface mic_adc_sampler_if;

    logic adc_sclk;
    logic adc_cs_n;
    logic adc_miso;

    modport master (
        output adc_sclk,
        output adc_cs_n,
        input  adc_miso
    );

    modport slave (
        input  adc_sclk,
        input  adc_cs_n,
        output adc_miso
    );

endinterface

// File: rtl/mic_adc_sampler_timer.sv
// Modulo-PERIOD counter with run enable and a one-cycle wrap pulse;
// usable for any sample-rate strobe.
module sample_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic wrap_o
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign wrap_o  = en_i & at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mic_adc_sampler.sv
// Periodic MCP3201-style serial ADC reader producing a D_WIDTH-bit
// mic sample and a one-cycle sample-rate strobe for the delay stage.
module mic_adc_sampler
    import mic_adc_pkg::*;
#(
    parameter int D_WIDTH       = 8,
    parameter int ADC_BITS      = ADC_BITS_D,
    parameter int NULL_BITS     = NULL_BITS_D,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter bit CHECK_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    mic_adc_sampler_if.master  adc,
    output logic [D_WIDTH-1:0] mic_signal,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int FB     = NULL_BITS + ADC_BITS;
    localparam int HALVES = 2 * FB;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HC_W   = $clog2(HALVES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HALVES - 1);

    if (CHECK_EN &&
        (SAMPLE_PERIOD <= frame_latency(CLK_DIV, FB) + 1))
    begin : g_bad_period
        $fatal(1, "SAMPLE_PERIOD shorter than one ADC frame");
    end

    if (D_WIDTH > ADC_BITS) begin : g_bad_width
        $fatal(1, "D_WIDTH wider than ADC_BITS");
    end

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [HC_W-1:0]      hc_q, hc_d;
    logic [ADC_BITS-1:0]  shift_q, shift_d;
    logic [D_WIDTH-1:0]   mic_q, mic_d;
    logic                 sclk_q, sclk_d;
    logic                 sclk_p_q;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 req;
    logic                 div_end;
    logic                 rise;

    sample_timer #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .wrap_o (req)
    );

    assign div_end = (div_q == DIV_LAST);
    // Sample one clk after the registered rise: mid-bit for the ADC.
    assign rise    = sclk_q & ~sclk_p_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hc_d    = hc_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        mic_d   = mic_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q | (req & (state_q != IDLE));
        shift_d = rise ? {shift_q[ADC_BITS-2:0], adc.adc_miso}
                       : shift_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                    hc_d    = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    // Last low half doubles as CS hold time.
                    if (hc_q == HC_LAST) begin
                        state_d = DONE;
                        sclk_d  = 1'b0;
                        cs_n_d  = 1'b1;
                    end else begin
                        sclk_d = ~sclk_q;
                        hc_d   = hc_q + HC_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                mic_d   = shift_q[ADC_BITS-1 -: D_WIDTH];
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            hc_q     <= '0;
            shift_q  <= '0;
            mic_q    <= '0;
            sclk_q   <= 1'b0;
            sclk_p_q <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            hc_q     <= hc_d;
            shift_q  <= shift_d;
            mic_q    <= mic_d;
            sclk_q   <= sclk_d;
            sclk_p_q <= sclk_q;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign adc.adc_sclk = sclk_q;
    assign adc.adc_cs_n = cs_n_q;
    assign mic_signal   = mic_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;

endmodule
